ledg_fade_pwm: RTL and testbench



---
 rtl/ledg_pkg.sv | 15 +
 rtl/ledg_fade_channel.sv | 52 +++++
 rtl/ledg_fade_pwm.sv | 76 +++++++
 tb/tb_ledg_fade_pwm.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledg_pkg.sv
// Shared constants and sizing helpers for the green-LED fade/PWM block.
package ledg_pkg;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned lvl_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    localparam int unsigned PWM_BITS_DEF = 4;
    localparam int unsigned LVL_MAX      = lvl_max(PWM_BITS_DEF);

endpackage

// File: rtl/ledg_fade_channel.sv
// One LED channel: brightness level that ramps or snaps toward its on/off target,
// plus the registered PWM compare against the shared counter.
module ledg_fade_channel
    import ledg_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                fade_en,
    input  logic                fade_step,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic                out_bit,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] LMAX = PWM_BITS'(lvl_max(PWM_BITS));

    logic [PWM_BITS-1:0] target_c;
    logic [PWM_BITS-1:0] level_next_c;

    // Next level: snap when fading is off, otherwise one saturating step per fade tick.
    always_comb begin
        target_c     = req ? LMAX : '0;
        level_next_c = level;
        if (!fade_en) begin
            level_next_c = target_c;
        end else if (fade_step) begin
            if (req && (level != LMAX)) begin
                level_next_c = level + PWM_BITS'(1);
            end else if (!req && (level != '0)) begin
                level_next_c = level - PWM_BITS'(1);
            end
        end
    end

    assign at_target = (level == target_c);

    // Full-scale level is forced on so the pwm_cnt wrap never produces a dark step.
    always_ff @(posedge clk) begin
        if (reset) begin
            level   <= '0;
            out_bit <= 1'b0;
        end else begin
            level   <= level_next_c;
            out_bit <= (level == LMAX) || (level > pwm_cnt);
        end
    end

endmodule

// File: rtl/ledg_fade_pwm.sv
// Green-LED driver: turns the PIO on/off word into soft-faded, PWM-dimmed LED outputs.
module ledg_fade_pwm
    import ledg_pkg::*;
#(
    parameter int unsigned WIDTH    = 9,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned PRESCALE = 1024,
    parameter int unsigned FADE_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] led_req,
    input  logic             fade_en,
    output logic [WIDTH-1:0] led_out,
    output logic             busy
);

    localparam int unsigned         PS_W    = cnt_width(PRESCALE);
    localparam int unsigned         FD_W    = cnt_width(FADE_DIV);
    localparam logic [PWM_BITS-1:0] PWM_MAX = PWM_BITS'(lvl_max(PWM_BITS));

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FD_W-1:0]     fade_cnt;
    logic [WIDTH-1:0]    led_req_q;
    logic                pwm_tick_c;
    logic                period_end_c;
    logic                fade_step_c;
    logic [WIDTH-1:0]    at_target_c;
    // Levels are consumed only through at_target/out_bit at this level.
    logic [PWM_BITS-1:0] level_unused_c [WIDTH];

    always_comb begin
        pwm_tick_c   = (prescaler == PS_W'(PRESCALE - 1));
        period_end_c = pwm_tick_c && (pwm_cnt == PWM_MAX);
        fade_step_c  = period_end_c && (fade_cnt == FD_W'(FADE_DIV - 1));
    end

    // Shared timebase, input capture and busy reduction.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            fade_cnt  <= '0;
            led_req_q <= '0;
            busy      <= 1'b0;
        end else begin
            prescaler <= pwm_tick_c ? '0 : prescaler + PS_W'(1);
            if (pwm_tick_c) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            if (period_end_c) begin
                fade_cnt <= fade_step_c ? '0 : fade_cnt + FD_W'(1);
            end
            led_req_q <= led_req;
            busy      <= ~&at_target_c;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        ledg_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .req       (led_req_q[i]),
            .fade_en   (fade_en),
            .fade_step (fade_step_c),
            .pwm_cnt   (pwm_cnt),
            .level     (level_unused_c[i]),
            .out_bit   (led_out[i]),
            .at_target (at_target_c[i])
        );
    end

endmodule

// File: tb/tb_ledg_fade_pwm.sv
// Bench for ledg_fade_pwm: directed scenarios plus random traffic against a cycle-count model.
module tb_ledg_fade_pwm;

    localparam int unsigned W     = 9;
    localparam int unsigned PB    = 2;
    localparam int unsigned PS    = 2;
    localparam int unsigned FD    = 1;
    localparam int unsigned LMAX  = (1 << PB) - 1;
    localparam int unsigned STEPS = 1 << PB;
    localparam int unsigned FPER  = PS * STEPS * FD;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] led_req = '0;
    logic         fade_en = 1'b0;
    logic [W-1:0] led_out;
    logic         busy;

    int tests = 0;
    int fails = 0;

    // Reference state: time since reset as a plain cycle count, levels as integers.
    int           m_k;
    int           m_level [W];
    int           m_nl [W];
    logic [W-1:0] m_req_q;
    logic [W-1:0] m_out;
    logic [W-1:0] m_no;
    logic         m_busy;
    logic         m_nb;
    int           m_pwm;
    int           m_tgt;
    bit           m_fstep;

    always #5 clk = ~clk;

    ledg_fade_pwm #(
        .WIDTH    (W),
        .PWM_BITS (PB),
        .PRESCALE (PS),
        .FADE_DIV (FD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .led_req (led_req),
        .fade_en (fade_en),
        .led_out (led_out),
        .busy    (busy)
    );

    always @(posedge clk) begin
        if (reset) begin
            m_k = 0;
            for (int i = 0; i < W; i++) m_level[i] = 0;
            m_req_q = '0;
            m_out   = '0;
            m_busy  = 1'b0;
        end else begin
            m_pwm   = (m_k / PS) % STEPS;
            m_fstep = (m_k % FPER) == (FPER - 1);
            m_nb    = 1'b0;
            for (int i = 0; i < W; i++) begin
                m_tgt = m_req_q[i] ? LMAX : 0;
                if (m_level[i] != m_tgt) m_nb = 1'b1;
                m_no[i] = (m_level[i] == LMAX) || (m_level[i] > m_pwm);
                if (!fade_en)                              m_nl[i] = m_tgt;
                else if (m_fstep && m_tgt > m_level[i])    m_nl[i] = m_level[i] + 1;
                else if (m_fstep && m_tgt < m_level[i])    m_nl[i] = m_level[i] - 1;
                else                                       m_nl[i] = m_level[i];
            end
            for (int i = 0; i < W; i++) m_level[i] = m_nl[i];
            m_out   = m_no;
            m_busy  = m_nb;
            m_req_q = led_req;
            m_k     = m_k + 1;
        end
    end

    task automatic test_reset();
        reset   = 1'b1;
        led_req = 9'h1FF;
        fade_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (led_out !== '0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: led_out=%h busy=%b expected led_out=000 busy=0", led_out, busy);
            end
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (led_out !== m_out || busy !== m_busy) begin
                fails++;
                $display("FAIL reset_release_track: led_out=%h busy=%b expected %h %b", led_out, busy, m_out, m_busy);
            end
        end
        tests++;
        if (led_out !== 9'h1FF) begin
            fails++;
            $display("FAIL reset_release_snap: led_out=%h expected 1ff", led_out);
        end
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_release_busy: busy=%b expected 0", busy);
            end
        end
    endtask

    task automatic test_fade_in();
        fade_en = 1'b0;
        led_req = '0;
        repeat (3) @(negedge clk);
        fade_en = 1'b1;
        led_req = 9'h001;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL fade_in_busy_rise: busy=%b expected 1", busy);
        end
        repeat (40) begin
            @(negedge clk);
            tests++;
            if (led_out !== m_out || busy !== m_busy || led_out[8:1] !== 8'h00) begin
                fails++;
                $display("FAIL fade_in_track: led_out=%h busy=%b expected %h %b", led_out, busy, m_out, m_busy);
            end
        end
        repeat (8) begin
            @(negedge clk);
            tests++;
            if (led_out !== 9'h001 || busy !== 1'b0) begin
                fails++;
                $display("FAIL fade_in_full: led_out=%h busy=%b expected 001 0", led_out, busy);
            end
        end
    endtask

    task automatic test_fade_out();
        led_req = '0;
        repeat (40) begin
            @(negedge clk);
            tests++;
            if (led_out !== m_out || busy !== m_busy) begin
                fails++;
                $display("FAIL fade_out_track: led_out=%h busy=%b expected %h %b", led_out, busy, m_out, m_busy);
            end
        end
        repeat (8) begin
            @(negedge clk);
            tests++;
            if (led_out !== '0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL fade_out_dark: led_out=%h busy=%b expected 000 0", led_out, busy);
            end
        end
    endtask

    task automatic test_reversal();
        int n;
        int run;
        int max_run;
        n = 0;
        led_req = 9'h001;
        while (m_level[0] != 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL reversal_wait: level 2 not reached in %0d cycles", n);
        end
        led_req = '0;
        run     = 0;
        max_run = 0;
        repeat (40) begin
            @(negedge clk);
            run = led_out[0] ? run + 1 : 0;
            if (run > max_run) max_run = run;
            tests++;
            if (led_out !== m_out || busy !== m_busy) begin
                fails++;
                $display("FAIL reversal_track: led_out=%h busy=%b expected %h %b", led_out, busy, m_out, m_busy);
            end
        end
        tests++;
        if (max_run >= int'(2 * STEPS) || led_out[0] !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reversal_no_full: max_high_run=%0d led0=%b busy=%b expected run<%0d led0=0 busy=0",
                     max_run, led_out[0], busy, 2 * STEPS);
        end
    endtask

    task automatic test_snap();
        int n;
        n = 0;
        fade_en = 1'b1;
        led_req = 9'h1FF;
        while (m_level[0] != 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL snap_wait: level 1 not reached in %0d cycles", n);
        end
        fade_en = 1'b0;
        @(negedge clk);
        tests++;
        if (led_out !== m_out || busy !== m_busy) begin
            fails++;
            $display("FAIL snap_track: led_out=%h busy=%b expected %h %b", led_out, busy, m_out, m_busy);
        end
        @(negedge clk);
        tests++;
        if (led_out !== 9'h1FF || busy !== 1'b0) begin
            fails++;
            $display("FAIL snap_full: led_out=%h busy=%b expected 1ff 0", led_out, busy);
        end
    endtask

    task automatic test_reset_mid();
        fade_en = 1'b1;
        led_req = '0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (led_out !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_clear: led_out=%h busy=%b expected 000 0", led_out, busy);
        end
        reset   = 1'b0;
        led_req = 9'h1FF;
        repeat (45) begin
            @(negedge clk);
            tests++;
            if (led_out !== m_out || busy !== m_busy) begin
                fails++;
                $display("FAIL reset_mid_track: led_out=%h busy=%b expected %h %b", led_out, busy, m_out, m_busy);
            end
        end
        tests++;
        if (led_out !== 9'h1FF || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_restart: led_out=%h busy=%b expected 1ff 0", led_out, busy);
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            reset = ($urandom_range(59) == 0);
            if ($urandom_range(39) == 0) fade_en = ~fade_en;
            if ($urandom_range(11) == 0) led_req = W'($urandom);
            @(negedge clk);
            tests++;
            if (led_out !== m_out || busy !== m_busy) begin
                fails++;
                $display("FAIL random_track: led_out=%h busy=%b expected %h %b", led_out, busy, m_out, m_busy);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_fade_out();
        test_reversal();
        test_snap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
